// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch mode controller: FSM states and
// digit blank patterns for the seven-segment display.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_ADJ  = 2'b10,
    ST_CLR  = 2'b11
  } state_t;

  localparam logic [3:0] BLANK_SEC  = 4'b0011;
  localparam logic [3:0] BLANK_MIN  = 4'b1100;
  localparam logic [3:0] BLANK_NONE = 4'b0000;

  // Digits being adjusted blink; sel_sw picks which pair.
  function automatic logic [3:0] blank_for(input logic phase, input logic sel);
    if (!phase) begin
      return BLANK_NONE;
    end
    return sel ? BLANK_MIN : BLANK_SEC;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge_pulse.sv
// Rising-edge detector for a debounced button level. History resets to 1 so a
// button already held when reset releases does not produce an event.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= 1'b1;
    end else begin
      r_hist <= i_level;
    end
  end

  assign o_rise = i_level & ~r_hist;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode/sequencing controller: turns button edges, switch levels and
// divider ticks into registered one-cycle counter commands plus a blink mask.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter bit          RUN_ON_RESET = 1'b0,
  parameter int unsigned CLR_PULSE_W  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_btn,
  input  logic       pause_btn,
  input  logic       adj_sw,
  input  logic       sel_sw,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
  output logic       cnt_inc,
  output logic       adj_inc_sec,
  output logic       adj_inc_min,
  output logic       cnt_clr,
  output logic       paused,
  output logic [3:0] blank_mask,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = (CLR_PULSE_W < 2) ? 1 : $clog2(CLR_PULSE_W + 1);
  // Counter holds clear cycles still owed after the current one.
  localparam logic [CNT_W-1:0] CLR_RELOAD = CNT_W'(CLR_PULSE_W - 1);
  localparam state_t RESET_ST = RUN_ON_RESET ? ST_RUN : ST_STOP;

  logic w_clr_evt;
  logic w_pause_evt;

  edge_pulse u_clr_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (clr_btn),
    .o_rise  (w_clr_evt)
  );

  edge_pulse u_pause_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (pause_btn),
    .o_rise  (w_pause_evt)
  );

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_clr_left;
  logic [CNT_W-1:0] w_clr_left_next;
  logic             r_phase;
  logic             w_phase_next;
  logic             r_cnt_inc;
  logic             r_adj_inc_sec;
  logic             r_adj_inc_min;
  logic             r_cnt_clr;
  logic             r_paused;
  logic [3:0]       r_blank_mask;
  logic             w_cnt_inc_next;
  logic             w_adj_inc_sec_next;
  logic             w_adj_inc_min_next;
  logic             w_cnt_clr_next;
  logic             w_paused_next;
  logic [3:0]       w_blank_mask_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RESET_ST;
      r_clr_left    <= '0;
      r_phase       <= 1'b0;
      r_cnt_inc     <= 1'b0;
      r_adj_inc_sec <= 1'b0;
      r_adj_inc_min <= 1'b0;
      r_cnt_clr     <= 1'b0;
      r_paused      <= (RESET_ST != ST_RUN);
      r_blank_mask  <= BLANK_NONE;
    end else begin
      r_state       <= w_state_next;
      r_clr_left    <= w_clr_left_next;
      r_phase       <= w_phase_next;
      r_cnt_inc     <= w_cnt_inc_next;
      r_adj_inc_sec <= w_adj_inc_sec_next;
      r_adj_inc_min <= w_adj_inc_min_next;
      r_cnt_clr     <= w_cnt_clr_next;
      r_paused      <= w_paused_next;
      r_blank_mask  <= w_blank_mask_next;
    end
  end

  // Clear outranks everything, including a clear already in progress.
  always_comb begin
    w_state_next    = r_state;
    w_clr_left_next = r_clr_left;
    if (w_clr_evt) begin
      w_state_next    = ST_CLR;
      w_clr_left_next = CLR_RELOAD;
    end else begin
      case (r_state)
        ST_CLR: begin
          if (r_clr_left != '0) begin
            w_clr_left_next = r_clr_left - CNT_W'(1);
          end else begin
            w_state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          if (adj_sw) begin
            w_state_next = ST_ADJ;
          end else if (w_pause_evt) begin
            w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (adj_sw) begin
            w_state_next = ST_ADJ;
          end else if (w_pause_evt) begin
            w_state_next = ST_STOP;
          end
        end
        default: begin
          if (!adj_sw) begin
            w_state_next = ST_STOP;
          end
        end
      endcase
    end
  end

  // Ticks only act when the state is stable across the edge, so any
  // competing clear/adj/pause event drops the tick.
  always_comb begin
    w_cnt_inc_next     = (r_state == ST_RUN) && (w_state_next == ST_RUN) && tick_1hz;
    w_adj_inc_sec_next = (r_state == ST_ADJ) && (w_state_next == ST_ADJ) && tick_2hz && !sel_sw;
    w_adj_inc_min_next = (r_state == ST_ADJ) && (w_state_next == ST_ADJ) && tick_2hz && sel_sw;
    w_cnt_clr_next     = (w_state_next == ST_CLR);
    w_paused_next      = (w_state_next != ST_RUN);
    w_phase_next       = 1'b0;
    if (w_state_next == ST_ADJ) begin
      w_phase_next = r_phase ^ ((r_state == ST_ADJ) && tick_blink);
    end
    w_blank_mask_next  = blank_for(w_phase_next, sel_sw);
  end

  assign cnt_inc     = r_cnt_inc;
  assign adj_inc_sec = r_adj_inc_sec;
  assign adj_inc_min = r_adj_inc_min;
  assign cnt_clr     = r_cnt_clr;
  assign paused      = r_paused;
  assign blank_mask  = r_blank_mask;
  assign state       = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and randomized checks of stopwatch_ctrl against a cycle-level
// behavioural model of the mode rules.
module tb_stopwatch_ctrl;

  localparam int W = 2;
  localparam int M_STOP = 0, M_RUN = 1, M_ADJ = 2, M_CLR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_btn = 1'b0, pause_btn = 1'b0, adj_sw = 1'b0, sel_sw = 1'b0;
  logic tick_1hz = 1'b0, tick_2hz = 1'b0, tick_blink = 1'b0;
  logic cnt_inc, adj_inc_sec, adj_inc_min, cnt_clr, paused;
  logic [3:0] blank_mask;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  int   m_mode;
  int   m_clr_emitted;
  bit   m_prev_clr, m_prev_pause, m_phase;
  logic e_inc, e_sec, e_min, e_clr, e_paused;
  logic [3:0] e_blank;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.RUN_ON_RESET(1'b0), .CLR_PULSE_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_btn     (clr_btn),
    .pause_btn   (pause_btn),
    .adj_sw      (adj_sw),
    .sel_sw      (sel_sw),
    .tick_1hz    (tick_1hz),
    .tick_2hz    (tick_2hz),
    .tick_blink  (tick_blink),
    .cnt_inc     (cnt_inc),
    .adj_inc_sec (adj_inc_sec),
    .adj_inc_min (adj_inc_min),
    .cnt_clr     (cnt_clr),
    .paused      (paused),
    .blank_mask  (blank_mask),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_STOP;
    m_clr_emitted = 0;
    m_prev_clr = 1'b1;
    m_prev_pause = 1'b1;
    m_phase = 1'b0;
    e_inc = 0; e_sec = 0; e_min = 0; e_clr = 0;
    e_paused = 1'b1;
    e_blank = 4'h0;
  endtask

  // One clock of the mode rules, evaluated on the inputs present at the edge.
  task automatic model_step();
    bit ce, pe;
    ce = clr_btn && !m_prev_clr;
    pe = pause_btn && !m_prev_pause;
    m_prev_clr = clr_btn;
    m_prev_pause = pause_btn;
    e_inc = 0; e_sec = 0; e_min = 0; e_clr = 0;
    if (ce) begin
      m_mode = M_CLR;
      m_clr_emitted = 0;
    end else begin
      case (m_mode)
        M_STOP: if (adj_sw) m_mode = M_ADJ; else if (pe) m_mode = M_RUN;
        M_RUN: begin
          if (adj_sw) m_mode = M_ADJ;
          else if (pe) m_mode = M_STOP;
          else if (tick_1hz) e_inc = 1;
        end
        M_ADJ: begin
          if (!adj_sw) m_mode = M_STOP;
          else begin
            if (tick_2hz) begin
              if (sel_sw) e_min = 1; else e_sec = 1;
            end
            if (tick_blink) m_phase = !m_phase;
          end
        end
        default: if (m_clr_emitted >= W) m_mode = M_STOP;
      endcase
    end
    if (m_mode == M_CLR) begin
      e_clr = 1;
      m_clr_emitted++;
    end
    if (m_mode != M_ADJ) m_phase = 0;
    e_blank = !m_phase ? 4'b0000 : (sel_sw ? 4'b1100 : 4'b0011);
    e_paused = (m_mode != M_RUN);
  endtask

  task automatic check_all();
    chk("cnt_inc", {3'b0, cnt_inc}, {3'b0, e_inc});
    chk("adj_inc_sec", {3'b0, adj_inc_sec}, {3'b0, e_sec});
    chk("adj_inc_min", {3'b0, adj_inc_min}, {3'b0, e_min});
    chk("cnt_clr", {3'b0, cnt_clr}, {3'b0, e_clr});
    chk("paused", {3'b0, paused}, {3'b0, e_paused});
    chk("blank_mask", blank_mask, e_blank);
    chk("state", {2'b0, state}, 4'(m_mode));
    chk("exclusive", 4'($countones({cnt_inc, adj_inc_sec, adj_inc_min, cnt_clr}) <= 1), 4'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic c, input logic p, input logic a, input logic s,
                       input logic t1, input logic t2, input logic tb);
    clr_btn = c; pause_btn = p; adj_sw = a; sel_sw = s;
    tick_1hz = t1; tick_2hz = t2; tick_blink = tb;
    cyc();
  endtask

  task automatic do_reset(input logic hold_pause);
    rst = 1'b0;
    clr_btn = 0; pause_btn = hold_pause; adj_sw = 0; sel_sw = 0;
    tick_1hz = 0; tick_2hz = 0; tick_blink = 0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  int n_inc, n_min, n_sec, n_clr;

  initial begin
    #2;
    // 1: stopped after reset, ticks ignored.
    do_reset(1'b0);
    repeat (3) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    chk("t1_state", {2'b0, state}, 4'd0);

    // 2: start, five seconds.
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    n_inc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      n_inc += int'(cnt_inc);
      drive(0, 0, 0, 0, 0, 0, 0);
      n_inc += int'(cnt_inc);
    end
    chk("t2_inc_count", 4'(n_inc), 4'd5);

    // 3: pause coincident with a tick drops the tick.
    drive(0, 1, 0, 0, 1, 0, 0);
    chk("t3_no_inc", {3'b0, cnt_inc}, 4'd0);
    chk("t3_state", {2'b0, state}, 4'd0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // 4: adjust minutes with blink.
    drive(0, 0, 1, 1, 0, 0, 0);
    n_min = 0; n_sec = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 0, 1, (i == 0 || i == 2));
      n_min += int'(adj_inc_min);
      n_sec += int'(adj_inc_sec);
      if (i == 0) chk("t4_blank_on", blank_mask, 4'b1100);
      if (i == 2) chk("t4_blank_off", blank_mask, 4'b0000);
      drive(0, 0, 1, 1, 0, 0, 0);
    end
    chk("t4_min_count", 4'(n_min), 4'd4);
    chk("t4_sec_count", 4'(n_sec), 4'd0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t4_exit_state", {2'b0, state}, 4'd0);

    // 5: clear from run, then a restarted clear.
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    n_clr = 0; n_inc = 0;
    drive(1, 0, 0, 0, 0, 0, 0); n_clr += int'(cnt_clr);
    drive(1, 0, 0, 0, 1, 0, 0); n_clr += int'(cnt_clr); n_inc += int'(cnt_inc);
    drive(0, 0, 0, 0, 1, 0, 0); n_clr += int'(cnt_clr); n_inc += int'(cnt_inc);
    drive(0, 0, 0, 0, 0, 0, 0); n_clr += int'(cnt_clr);
    chk("t5_clr_len", 4'(n_clr), 4'd2);
    chk("t5_no_inc", 4'(n_inc), 4'd0);
    chk("t5_state", {2'b0, state}, 4'd0);
    n_clr = 0;
    drive(1, 0, 0, 0, 0, 0, 0); n_clr += int'(cnt_clr);
    drive(0, 0, 0, 0, 0, 0, 0); n_clr += int'(cnt_clr);
    drive(1, 0, 0, 0, 0, 0, 0); n_clr += int'(cnt_clr);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0); n_clr += int'(cnt_clr);
    end
    chk("t5_restart_len", 4'(n_clr), 4'd4);

    // 6: pause held through reset release is not an event.
    do_reset(1'b1);
    repeat (3) drive(0, 1, 0, 0, 1, 0, 0);
    chk("t6_held_state", {2'b0, state}, 4'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("t6_repress_state", {2'b0, state}, 4'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic a, s;
      a = ($urandom_range(0, 19) == 0) ? ~adj_sw : adj_sw;
      s = ($urandom_range(0, 7) == 0) ? ~sel_sw : sel_sw;
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, a, s,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
